// File: rtl/weight_bank_streamer.sv
// rtl/weight_bank_streamer.sv - multi-bank weight RAM with lockstep burst read-out under valid/ready
module weight_bank_streamer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5,
    parameter int BANKS  = 10,
    parameter int BANK_W = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      WR_EN,
    input  logic [BANK_W-1:0]         WR_BANK,
    input  logic [ADDR_W-1:0]         WR_ADDR,
    input  logic [DATA_W-1:0]         WR_DATA,
    input  logic                      START,
    input  logic [ADDR_W-1:0]         BASE,
    input  logic [ADDR_W:0]           LEN,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [BANKS*DATA_W-1:0]   DOUT,
    output logic                      DOUT_VALID,
    input  logic                      DOUT_READY,
    output logic                      DOUT_LAST
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [BANK_W:0]   BANKS_L  = (BANK_W+1)'(BANKS);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_rd_addr;
    logic [ADDR_W:0]         r_len;
    logic [ADDR_W:0]         r_issued;
    logic                    r_fin_hold;
    logic                    r_q_valid;
    logic                    r_q_last;
    logic [BANKS*DATA_W-1:0] w_rdata;
    logic [BANKS*DATA_W-1:0] r_fifo_d [2];
    logic [1:0]              r_fifo_l;
    logic                    r_wptr;
    logic                    r_rptr;
    logic [1:0]              r_cnt;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_wr_ok;
    logic                    w_start;
    logic [ADDR_W:0]         w_len_eff;
    logic [31:0]             w_base_wide;
    logic [ADDR_W-1:0]       w_base_mod;

    assign w_len_eff    = (LEN > DEPTH_L) ? DEPTH_L : LEN;
    assign w_base_wide  = 32'(BASE);
    assign w_base_mod   = ADDR_W'(w_base_wide % DEPTH);
    assign w_start      = (r_state == S_IDLE) && START;
    assign w_wr_ok      = WR_EN && (r_state == S_IDLE) && ({1'b0, WR_ADDR} < DEPTH_L)
                          && ({1'b0, WR_BANK} < BANKS_L);
    assign w_pop        = (r_cnt != 2'd0) && DOUT_READY;
    assign w_push       = r_q_valid;
    // Issue only if the entry can be guaranteed a FIFO slot when it lands next cycle.
    assign w_issue      = (r_state == S_RUN)
                          && (({1'b0, r_cnt} + {2'b00, r_q_valid}) < (3'd2 + {2'b00, w_pop}));
    assign w_issue_last = w_issue && ((r_issued + (ADDR_W+1)'(1)) == r_len);

    assign DOUT         = r_fifo_d[r_rptr];
    assign DOUT_VALID   = (r_cnt != 2'd0);
    assign DOUT_LAST    = DOUT_VALID && r_fifo_l[r_rptr];

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [DATA_W-1:0] r_q;
        // One bank: loader write port plus registered lockstep read, contents survive reset.
        always_ff @(posedge CLK) begin
            if (w_wr_ok && (WR_BANK == BANK_W'(b))) begin
                r_mem[WR_ADDR] <= WR_DATA;
            end
            if (w_issue) begin
                r_q <= r_mem[r_rd_addr];
            end
        end
        assign w_rdata[b*DATA_W +: DATA_W] = r_q;
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs; a zero-length burst waits one cycle in FIN before DONE.
    always_comb begin
        w_state_nxt = r_state;
        BUSY        = (r_state != S_IDLE);
        DONE        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = (w_len_eff == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && r_fifo_l[r_rptr]) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                if (!r_fin_hold) begin
                    DONE        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst bookkeeping: captured base/length, read address walk modulo DEPTH, in-flight tag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd_addr  <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_fin_hold <= 1'b0;
            r_q_valid  <= 1'b0;
            r_q_last   <= 1'b0;
        end else begin
            r_q_valid <= w_issue;
            r_q_last  <= w_issue_last;
            if (w_start) begin
                r_rd_addr  <= w_base_mod;
                r_len      <= w_len_eff;
                r_issued   <= '0;
                r_fin_hold <= (w_len_eff == '0);
            end else begin
                if (r_state == S_FIN) begin
                    r_fin_hold <= 1'b0;
                end
                if (w_issue) begin
                    r_issued  <= r_issued + (ADDR_W+1)'(1);
                    r_rd_addr <= (r_rd_addr == LAST_ADR) ? '0 : r_rd_addr + ADDR_W'(1);
                end
            end
        end
    end

    // Two-entry output FIFO holding wide beats and their LAST flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_d[i] <= '0;
            end
            r_fifo_l <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_fifo_d[r_wptr] <= w_rdata;
                r_fifo_l[r_wptr] <= r_q_last;
                r_wptr           <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_weight_bank_streamer.sv
// tb/tb_weight_bank_streamer.sv - self-checking bench for weight_bank_streamer
module tb_weight_bank_streamer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 28;
    localparam int ADDR_W = 5;
    localparam int BANKS  = 10;
    localparam int BANK_W = 4;
    localparam int DW     = BANKS * DATA_W;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic              WR_EN;
    logic [BANK_W-1:0] WR_BANK;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              START;
    logic [ADDR_W-1:0] BASE;
    logic [ADDR_W:0]   LEN;
    logic              BUSY;
    logic              DONE;
    logic [DW-1:0]     DOUT;
    logic              DOUT_VALID;
    logic              DOUT_READY;
    logic              DOUT_LAST;

    weight_bank_streamer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BANKS(BANKS), .BANK_W(BANK_W)
    ) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_BANK(WR_BANK), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .START(START), .BASE(BASE), .LEN(LEN), .BUSY(BUSY),
        .DONE(DONE), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
        .DOUT_LAST(DOUT_LAST)
    );

    always #5 CLK = ~CLK;

    logic [DATA_W-1:0] model [BANKS][DEPTH];
    beat_t             exp_q[$];
    logic [DW-1:0]     obs[$];
    int                checks = 0;
    int                failures = 0;
    int                beats_seen = 0;
    bit                done_due = 0;
    bit                zero_mode = 0;
    bit                prev_stall = 0;
    logic [DW-1:0]     prev_d;
    logic              prev_l;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
        end
    endtask

    // Compare process: every beat, stall hold, DONE pulse against the expected-beat queue.
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 0;
            done_due   = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", DOUT_VALID, 1);
                chk("stall_data", DOUT, prev_d);
                chk("stall_last", DOUT_LAST, prev_l);
            end
            if (done_due) begin
                chk("done_pulse", DONE, 1);
                chk("busy_in_done", BUSY, 1);
            end else if (!zero_mode) begin
                chk("done_idle", DONE, 0);
            end
            done_due = 0;
            if (DOUT_VALID && exp_q.size() == 0) begin
                chk("unexpected_beat", DOUT_VALID, 0);
            end else if (DOUT_VALID && DOUT_READY) begin
                chk("beat_data", DOUT, exp_q[0].d);
                chk("beat_last", DOUT_LAST, exp_q[0].l);
                if (exp_q[0].l) done_due = 1;
                obs.push_back(DOUT);
                beats_seen++;
                exp_q.delete(0);
            end
            prev_stall = DOUT_VALID && !DOUT_READY;
            prev_d     = DOUT;
            prev_l     = DOUT_LAST;
        end
    end

    task automatic expect_beats(input int base, input int leff);
        int a;
        a = base % DEPTH;
        for (int i = 0; i < leff; i++) begin
            beat_t bt;
            for (int b = 0; b < BANKS; b++) begin
                bt.d[b*DATA_W +: DATA_W] = model[b][(a + i) % DEPTH];
            end
            bt.l = (i == leff - 1);
            exp_q.push_back(bt);
        end
    endtask

    task automatic burst(input int base, input int len, input bit bp, input bit poke);
        int         leff;
        int         n;
        bit         seen;
        logic [5:0] pat;
        pat  = 6'b101001;
        leff = (len > DEPTH) ? DEPTH : len;
        obs.delete();
        beats_seen = 0;
        expect_beats(base, leff);
        zero_mode = (leff == 0);
        @(posedge CLK); #1;
        START = 1'b1;
        BASE  = ADDR_W'(base);
        LEN   = (ADDR_W+1)'(len);
        @(posedge CLK); #1;
        START      = 1'b0;
        DOUT_READY = bp ? pat[0] : 1'b1;
        n    = 0;
        seen = 0;
        while (!seen && n < 300) begin
            @(negedge CLK);
            n++;
            if (n == 1) chk("busy_after_start", BUSY, 1);
            if (!bp && leff > 0 && n == 2) chk("first_valid_low", DOUT_VALID, 0);
            if (!bp && leff > 0 && n == 3) chk("first_valid_high", DOUT_VALID, 1);
            if (DONE) begin
                seen = 1;
                if (!bp) chk("done_latency", n, (leff == 0) ? 2 : leff + 3);
            end
            @(posedge CLK); #1;
            DOUT_READY = bp ? pat[n % 6] : 1'b1;
            if (poke && n == 4) begin
                START   = 1'b1;
                BASE    = ADDR_W'(7);
                LEN     = (ADDR_W+1)'(5);
                WR_EN   = 1'b1;
                WR_BANK = BANK_W'(2);
                WR_ADDR = ADDR_W'(5);
                WR_DATA = 16'hDEAD;
            end else begin
                START = 1'b0;
                WR_EN = 1'b0;
            end
        end
        chk("done_seen", seen, 1);
        @(negedge CLK);
        chk("busy_after_done", BUSY, 0);
        chk("all_beats_out", exp_q.size(), 0);
        zero_mode = 0;
    endtask

    task automatic wr(input int b, input int a, input int d);
        @(posedge CLK); #1;
        WR_EN   = 1'b1;
        WR_BANK = BANK_W'(b);
        WR_ADDR = ADDR_W'(a);
        WR_DATA = DATA_W'(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] v;
        int            n;
        RST = 1'b1; WR_EN = 1'b0; WR_BANK = '0; WR_ADDR = '0; WR_DATA = '0;
        START = 1'b0; BASE = '0; LEN = '0; DOUT_READY = 1'b0;
        @(posedge CLK); #1;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_valid", DOUT_VALID, 0);
        chk("rst_last", DOUT_LAST, 0);
        chk("rst_dout", DOUT, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        for (int b = 0; b < BANKS; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                wr(b, a, b * 256 + a);
                model[b][a] = DATA_W'(b * 256 + a);
            end
        end
        wr(10, 0, 16'hFFFF);
        wr(1, 30, 16'hFFFF);
        @(posedge CLK); #1;
        WR_EN = 1'b0;

        burst(0, 28, 0, 0);
        chk("full_count", obs.size(), 28);
        v = obs[0];
        chk("full_beat0_bank3", v[3*DATA_W +: DATA_W], 16'h0300);
        v = obs[27];
        chk("full_beat27_bank9", v[9*DATA_W +: DATA_W], 16'h091B);

        burst(25, 6, 0, 0);
        v = obs[2];
        chk("wrap_beat2_bank1", v[1*DATA_W +: DATA_W], 16'h011B);
        v = obs[3];
        chk("wrap_beat3_bank9", v[9*DATA_W +: DATA_W], 16'h0900);

        burst(0, 40, 0, 0);
        chk("clamp_count", obs.size(), 28);

        burst(3, 10, 1, 0);
        chk("bp_count", obs.size(), 10);
        v = obs[9];
        chk("bp_beat9_bank0", v[0 +: DATA_W], 16'h000C);

        burst(0, 0, 0, 0);
        chk("zero_count", obs.size(), 0);

        burst(10, 8, 0, 1);
        chk("poke_count", obs.size(), 8);

        burst(5, 1, 0, 0);
        v = obs[0];
        chk("busy_write_dropped", v[2*DATA_W +: DATA_W], 16'h0205);

        obs.delete();
        beats_seen = 0;
        expect_beats(0, 20);
        @(posedge CLK); #1;
        START = 1'b1; BASE = '0; LEN = (ADDR_W+1)'(20);
        @(posedge CLK); #1;
        START = 1'b0; DOUT_READY = 1'b1;
        n = 0;
        while (beats_seen < 4 && n < 50) begin
            @(posedge CLK);
            n++;
        end
        chk("reset_wait_beats", beats_seen, 4);
        #3;
        RST = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_dout", DOUT, 0);
        chk("midrst_valid", DOUT_VALID, 0);
        chk("midrst_last", DOUT_LAST, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_done", DONE, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        burst(0, 3, 0, 0);
        chk("post_rst_count", obs.size(), 3);
        v = obs[1];
        chk("post_rst_beat1_bank4", v[4*DATA_W +: DATA_W], 16'h0401);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
